// File: rtl/silife_pkg.sv
// Shared constants, scan-state encoding and row-word packing for the life grid display path.
package silife_pkg;

  localparam int GRID_WIDTH     = 8;
  localparam int GRID_HEIGHT    = 32;
  localparam int ROW_BITS       = 5;
  localparam int SCAN_WORD_BITS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SHIFT,
    S_LATCH,
    S_FEND
  } scan_state_e;

  // Word sent per row: row index zero-extended to one byte, then the cell byte.
  function automatic logic [SCAN_WORD_BITS-1:0] make_word(
    input logic [ROW_BITS-1:0]   row,
    input logic [GRID_WIDTH-1:0] cells
  );
    return {{(SCAN_WORD_BITS-GRID_WIDTH-ROW_BITS){1'b0}}, row, cells};
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// Parallel-load MSB-first shift register with divided serial clock; done marks the
// final cycle of bit 0's high phase.
module serial_shifter
  import silife_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [SCAN_WORD_BITS-1:0] word,
  output logic                      sclk,
  output logic                      sdata,
  output logic                      done
);

  localparam int                BIT_W    = $clog2(SCAN_WORD_BITS);
  localparam logic [7:0]        DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(SCAN_WORD_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);

  logic [SCAN_WORD_BITS-1:0] shreg;
  logic [7:0]                div_cnt;
  logic [BIT_W-1:0]          bit_cnt;
  logic                      active;
  logic                      hi;
  logic                      phase_end;

  assign phase_end = active && (div_cnt == DIV_LAST);
  assign done      = phase_end && hi && (bit_cnt == '0);
  // Data bit is the register MSB itself, so it only moves on the high-to-low step.
  assign sdata     = shreg[SCAN_WORD_BITS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
      hi      <= 1'b0;
      sclk    <= 1'b0;
    end else if (load) begin
      shreg   <= word;
      div_cnt <= '0;
      bit_cnt <= BIT_LAST;
      active  <= 1'b1;
      hi      <= 1'b0;
      sclk    <= 1'b0;
    end else if (active) begin
      if (!phase_end) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= '0;
        if (!hi) begin
          hi   <= 1'b1;
          sclk <= 1'b1;
        end else begin
          hi    <= 1'b0;
          sclk  <= 1'b0;
          // Shifting after the last bit too leaves the register, and sdata, at zero.
          shreg <= {shreg[SCAN_WORD_BITS-2:0], 1'b0};
          if (bit_cnt == '0) active  <= 1'b0;
          else               bit_cnt <= bit_cnt - BIT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/grid_scan_out.sv
// Scans every grid row out to a shift-register LED driver and issues a frame-aligned
// generation step so the grid only advances between complete frames.
module grid_scan_out
  import silife_pkg::*;
#(
  parameter int CLK_DIV         = 1,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [GRID_WIDTH-1:0] cells,
  output logic [ROW_BITS-1:0]   row_select,
  output logic                  sclk,
  output logic                  sdata,
  output logic                  slatch,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  step_en
);

  localparam logic [7:0]          DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0]          FPS_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(GRID_HEIGHT - 1);
  localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);

  scan_state_e               state, state_nxt;
  logic [ROW_BITS-1:0]       row, row_nxt;
  logic [7:0]                lat_cnt, lat_cnt_nxt;
  logic [7:0]                frame_cnt, frame_cnt_nxt;
  logic                      lat_hi, lat_hi_nxt;
  logic                      slatch_nxt, frame_done_nxt, step_en_nxt, busy_nxt;
  logic                      load, sh_done;
  logic [SCAN_WORD_BITS-1:0] word;

  assign row_select = row;
  assign word       = make_word(row, cells);

  serial_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .word  (word),
    .sclk  (sclk),
    .sdata (sdata),
    .done  (sh_done)
  );

  always_comb begin
    state_nxt      = state;
    row_nxt        = row;
    lat_cnt_nxt    = lat_cnt;
    lat_hi_nxt     = lat_hi;
    frame_cnt_nxt  = frame_cnt;
    slatch_nxt     = 1'b0;
    frame_done_nxt = 1'b0;
    step_en_nxt    = 1'b0;
    load           = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_nxt = S_SEL;
          row_nxt   = '0;
        end
      end
      S_SEL: begin
        load      = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (sh_done) begin
          state_nxt   = S_LATCH;
          slatch_nxt  = 1'b1;
          lat_cnt_nxt = '0;
          lat_hi_nxt  = 1'b1;
        end
      end
      S_LATCH: begin
        slatch_nxt = lat_hi;
        if (lat_cnt != DIV_LAST) begin
          lat_cnt_nxt = lat_cnt + 8'd1;
        end else if (lat_hi) begin
          lat_cnt_nxt = '0;
          lat_hi_nxt  = 1'b0;
          slatch_nxt  = 1'b0;
        end else if (row != ROW_LAST) begin
          lat_cnt_nxt = '0;
          row_nxt     = row + ROW_ONE;
          state_nxt   = S_SEL;
        end else begin
          // Frame pulses are registered, so they are decided on the edge entering FEND.
          lat_cnt_nxt    = '0;
          row_nxt        = '0;
          state_nxt      = S_FEND;
          frame_done_nxt = 1'b1;
          if (frame_cnt == FPS_LAST) begin
            step_en_nxt   = 1'b1;
            frame_cnt_nxt = '0;
          end else begin
            frame_cnt_nxt = frame_cnt + 8'd1;
          end
        end
      end
      S_FEND: begin
        state_nxt = run ? S_SEL : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        row_nxt   = '0;
      end
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      row        <= '0;
      lat_cnt    <= '0;
      lat_hi     <= 1'b0;
      frame_cnt  <= '0;
      slatch     <= 1'b0;
      frame_done <= 1'b0;
      step_en    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      lat_cnt    <= lat_cnt_nxt;
      lat_hi     <= lat_hi_nxt;
      frame_cnt  <= frame_cnt_nxt;
      slatch     <= slatch_nxt;
      frame_done <= frame_done_nxt;
      step_en    <= step_en_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule
